// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a push FIFO feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to build the parity bit (even, or odd when PARITY_ODD=1).
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx
);

    localparam int DIV = CLK_FREQ / BAUDRATE;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;
    localparam int BCW = $clog2(DIV);
    localparam int DCW = $clog2(DATA_BITS);
    localparam logic [BCW-1:0] BAUD_MAX = BCW'(DIV - 1);

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadConfig
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr_q, rdPtr_q;
    logic [LW-1:0]        level_q, level_d;
    logic                 full_q, empty_q, overflow_q;

    state_t               state_q;
    logic [BCW-1:0]       baudCnt_q;
    logic [DCW-1:0]       bitCnt_q;
    logic                 stopCnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q, busy_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic push, pop, baudDone, stopLast;

    // full is the registered flag, so a write while full is dropped even if a pop happens now
    always_comb begin
        push     = wr_en && !full_q;
        baudDone = (baudCnt_q == '0);
        stopLast = (state_q == STOP) && baudDone && (stopCnt_q == 1'(STOP_BITS - 1));
        pop      = !empty_q && ((state_q == IDLE) || stopLast);
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            level_q    <= level_d;
            full_q     <= (level_d == LW'(FIFO_DEPTH));
            empty_q    <= (level_d == '0);
            overflow_q <= wr_en && full_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            baudCnt_q <= BAUD_MAX;
            bitCnt_q  <= '0;
            stopCnt_q <= 1'b0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baudCnt_q <= BAUD_MAX;
                end
                START: begin
                    if (baudDone) begin
                        state_q   <= DATA;
                        tx_q      <= shift_q[0];
                        bitCnt_q  <= '0;
                        baudCnt_q <= BAUD_MAX;
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
                DATA: begin
                    if (baudDone) begin
                        baudCnt_q <= BAUD_MAX;
                        if (bitCnt_q == DCW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_q      <= parity_q;
`else
                            state_q   <= STOP;
                            tx_q      <= 1'b1;
                            stopCnt_q <= 1'b0;
`endif
                        end else begin
                            bitCnt_q <= bitCnt_q + 1'b1;
                            shift_q  <= shift_q >> 1;
                            tx_q     <= shift_q[1];
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baudDone) begin
                        state_q   <= STOP;
                        tx_q      <= 1'b1;
                        stopCnt_q <= 1'b0;
                        baudCnt_q <= BAUD_MAX;
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baudDone) begin
                        baudCnt_q <= BAUD_MAX;
                        if (stopLast) begin
                            state_q <= IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            stopCnt_q <= stopCnt_q + 1'b1;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase

            // A pop overrides the case above, chaining STOP straight into the next START
            if (pop) begin
                state_q   <= START;
                shift_q   <= mem[rdPtr_q];
                tx_q      <= 1'b0;
                busy_q    <= 1'b1;
                baudCnt_q <= BAUD_MAX;
`ifdef UART_TX_PARITY_EN
                parity_q  <= (^mem[rdPtr_q]) ^ 1'(PARITY_ODD);
`endif
            end
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DIV=10, 8 data bits, depth 4).
// With UART_TX_PARITY_EN defined it also runs odd parity with two stop bits.
module tb_uart_tx_fifo;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
    localparam int SBITS = 2;
`else
    localparam int PBITS = 0;
    localparam int SBITS = 1;
`endif
    localparam int FRAME = (1 + 8 + PBITS + SBITS) * DIV;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full, empty, overflow, busy, tx;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(
        .CLK_FREQ   (1000000),
        .BAUDRATE   (100000),
        .DATA_BITS  (8),
        .STOP_BITS  (SBITS),
        .PARITY_ODD (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Every step leaves the bench 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        step();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot b of a frame: start, 8 data LSB first, optional parity, stops
    function automatic logic expBit(input logic [7:0] data, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return data[b-1];
        if (PBITS == 1 && b == 9) return (^data) ^ 1'b1;
        return 1'b1;
    endfunction

    task automatic checkFrame(input logic [7:0] data, input int skip, input string tag);
        for (int idx = skip; idx < FRAME; idx++) begin
            checkOutput({tag, " tx"}, 32'(tx), 32'(expBit(data, idx / DIV)));
            checkOutput({tag, " busy"}, 32'(busy), 32'd1);
            step();
        end
    endtask

    logic [7:0] burst [6];

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        burst[0] = 8'hD1; burst[1] = 8'h2E; burst[2] = 8'h80; burst[3] = 8'h7F;
        burst[4] = 8'hEE; burst[5] = 8'h11;

        // Reset values
        repeat (3) step();
        rst = 1'b0;
        checkOutput("rst tx", 32'(tx), 32'd1);
        checkOutput("rst empty", 32'(empty), 32'd1);
        checkOutput("rst full", 32'(full), 32'd0);
        checkOutput("rst level", 32'(level), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst overflow", 32'(overflow), 32'd0);
        step();
        checkOutput("idle tx", 32'(tx), 32'd1);

        // Single word 0x65: tx falls one cycle after the write edge
        applyStimulus(1'b1, 8'h65);
        checkOutput("single empty", 32'(empty), 32'd0);
        checkOutput("single level", 32'(level), 32'd1);
        checkOutput("single tx pre", 32'(tx), 32'd1);
        checkOutput("single busy pre", 32'(busy), 32'd0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("single level pop", 32'(level), 32'd0);
        checkFrame(8'h65, 0, "single");
        checkOutput("single busy end", 32'(busy), 32'd0);
        checkOutput("single tx end", 32'(tx), 32'd1);
        checkOutput("single empty end", 32'(empty), 32'd1);

        // Burst of three words, frames back to back
        applyStimulus(1'b1, 8'h65);
        checkOutput("burst level1", 32'(level), 32'd1);
        applyStimulus(1'b1, 8'h00);
        checkOutput("burst level push+pop", 32'(level), 32'd1);
        checkOutput("burst tx start", 32'(tx), 32'd0);
        applyStimulus(1'b1, 8'h08);
        checkOutput("burst level peak", 32'(level), 32'd2);
        wr_en = 1'b0;
        checkFrame(8'h65, 1, "burst0");
        checkOutput("burst level after pop", 32'(level), 32'd1);
        checkFrame(8'h00, 0, "burst1");
        checkFrame(8'h08, 0, "burst2");
        checkOutput("burst busy end", 32'(busy), 32'd0);
        checkOutput("burst tx end", 32'(tx), 32'd1);
        checkOutput("burst level end", 32'(level), 32'd0);

        // Overflow: six writes while a frame is in flight, depth 4
        applyStimulus(1'b1, 8'hA1);
        applyStimulus(1'b0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, burst[i]);
            checkOutput("ovf level", 32'(level), (i < 4) ? 32'(i + 1) : 32'd4);
            checkOutput("ovf full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
            checkOutput("ovf pulse", 32'(overflow), (i >= 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf pulse end", 32'(overflow), 32'd0);
        checkOutput("ovf level hold", 32'(level), 32'd4);
        checkFrame(8'hA1, 7, "ovf0");
        checkOutput("ovf full after pop", 32'(full), 32'd0);
        for (int i = 0; i < 4; i++) begin
            checkFrame(burst[i], 0, "ovfq");
        end
        checkOutput("ovf busy end", 32'(busy), 32'd0);
        for (int c = 0; c < 2 * FRAME; c++) begin
            checkOutput("ovf no extra frame", 32'(tx), 32'd1);
            step();
        end

        // Reset during data bit 3 with two words still queued
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h3C);
        checkOutput("midrst level", 32'(level), 32'd2);
        wr_en = 1'b0;
        repeat (44) step();
        checkOutput("midrst bit3", 32'(tx), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst tx", 32'(tx), 32'd1);
        checkOutput("midrst level", 32'(level), 32'd0);
        checkOutput("midrst empty", 32'(empty), 32'd1);
        checkOutput("midrst busy", 32'(busy), 32'd0);
        for (int c = 0; c < 3 * FRAME; c++) begin
            checkOutput("midrst quiet", 32'(tx), 32'd1);
            step();
        end

`ifdef UART_TX_PARITY_EN
        // Odd parity of 0x08 is 0; frame is 12 bits with a 20-cycle stop phase
        applyStimulus(1'b1, 8'h08);
        applyStimulus(1'b0, 8'h00);
        checkOutput("par frame len", 32'(FRAME), 32'd120);
        checkOutput("par bit model", 32'(expBit(8'h08, 9)), 32'd0);
        checkFrame(8'h08, 0, "parity");
        checkOutput("par busy end", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
